// File: rtl/mac_ram_arbiter_if.sv
// Requester and RAM-side signal bundle for mac_ram_arbiter.
// Lock inputs exist only when ARB_LOCK_EN is defined.
interface mac_ram_arbiter_if #(
   parameter int unsigned data_w    = 32,
   parameter int unsigned ram_add_w = 9
);
   logic                 req0, we0, gnt0, rvalid0;
   logic [ram_add_w-1:0] addr0;
   logic [data_w-1:0]    wdata0, rdata0;
   logic                 req1, we1, gnt1, rvalid1;
   logic [ram_add_w-1:0] addr1;
   logic [data_w-1:0]    wdata1, rdata1;
`ifdef ARB_LOCK_EN
   logic                 lock0, lock1;
`endif
   logic                 ram_we;
   logic [ram_add_w-1:0] ram_addr;
   logic [data_w-1:0]    ram_w_data, ram_r_data;

   modport slave (
`ifdef ARB_LOCK_EN
      input  lock0, lock1,
`endif
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_r_data,
      output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
      output ram_we, ram_addr, ram_w_data
   );

   modport master (
`ifdef ARB_LOCK_EN
      output lock0, lock1,
`endif
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_r_data,
      input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
      input  ram_we, ram_addr, ram_w_data
   );
endinterface

// File: rtl/mac_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters, with read-data routing.
// Define ARB_LOCK_EN for hold-grant locking with a 16-grant starvation guard.
module mac_ram_arbiter #(
   parameter int unsigned data_w    = 32,
   parameter int unsigned ram_d     = 512,
   parameter int unsigned ram_add_w = $clog2(ram_d),
   parameter int unsigned RD_LAT    = 1
) (
   input  logic             clk,
   input  logic             rst,
   mac_ram_arbiter_if.slave bus
);
   logic                 w_pick1, w_gnt0, w_gnt1, w_any, w_we;
   logic [ram_add_w-1:0] w_addr;
   logic [data_w-1:0]    w_wdata;

   logic                 r_ptr;
   logic                 r_ram_we;
   logic [ram_add_w-1:0] r_ram_addr;
   logic [data_w-1:0]    r_ram_wdata;
   logic [RD_LAT:0]      r_tag_v, r_tag_o;
   logic                 r_rvalid0, r_rvalid1;
   logic [data_w-1:0]    r_rdata0, r_rdata1;

`ifdef ARB_LOCK_EN
   logic                 r_lk_v, r_owner;
   logic [3:0]           r_cnt;
   logic                 w_own_lock, w_win_lock;
`endif

   always_comb begin
      w_pick1 = bus.req1 & (~bus.req0 | r_ptr);
`ifdef ARB_LOCK_EN
      // A held lock overrides the pointer until 16 consecutive locked grants have gone by.
      w_own_lock = r_owner ? (bus.lock1 & bus.req1) : (bus.lock0 & bus.req0);
      if (r_lk_v && w_own_lock) begin
         if (r_cnt != 4'hF) w_pick1 = r_owner;
         else               w_pick1 = r_owner ? ~bus.req0 : bus.req1;
      end
      w_win_lock = w_pick1 ? bus.lock1 : bus.lock0;
`endif
      w_gnt0  = bus.req0 & ~w_pick1;
      w_gnt1  = w_pick1;
      w_any   = w_gnt0 | w_gnt1;
      w_we    = w_gnt1 ? bus.we1    : bus.we0;
      w_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
      w_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr       <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_tag_v     <= '0;
         r_tag_o     <= '0;
         r_rvalid0   <= 1'b0;
         r_rvalid1   <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
`ifdef ARB_LOCK_EN
         r_lk_v      <= 1'b0;
         r_owner     <= 1'b0;
         r_cnt       <= '0;
`endif
      end else begin
         r_ram_we <= w_any & w_we;
         if (w_any) begin
            r_ram_addr  <= w_addr;
            r_ram_wdata <= w_wdata;
         end
         // Tag slot RD_LAT lines up with the cycle ram_r_data is valid for that read.
         r_tag_v   <= {r_tag_v[RD_LAT-1:0], w_any & ~w_we};
         r_tag_o   <= {r_tag_o[RD_LAT-1:0], w_gnt1};
         r_rvalid0 <= r_tag_v[RD_LAT] & ~r_tag_o[RD_LAT];
         r_rvalid1 <= r_tag_v[RD_LAT] &  r_tag_o[RD_LAT];
         if (r_tag_v[RD_LAT] & ~r_tag_o[RD_LAT]) r_rdata0 <= bus.ram_r_data;
         if (r_tag_v[RD_LAT] &  r_tag_o[RD_LAT]) r_rdata1 <= bus.ram_r_data;
`ifdef ARB_LOCK_EN
         if (w_any) begin
            if (!w_win_lock) r_ptr <= ~w_gnt1;
            r_cnt   <= (r_lk_v && w_win_lock && (r_owner == w_gnt1)) ?
                       ((r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1) : '0;
            r_lk_v  <= w_win_lock;
            r_owner <= w_gnt1;
         end else begin
            r_lk_v  <= 1'b0;
         end
`else
         if (w_any) r_ptr <= ~w_gnt1;
`endif
      end
   end

   assign bus.gnt0       = w_gnt0;
   assign bus.gnt1       = w_gnt1;
   assign bus.rvalid0    = r_rvalid0;
   assign bus.rvalid1    = r_rvalid1;
   assign bus.rdata0     = r_rdata0;
   assign bus.rdata1     = r_rdata1;
   assign bus.ram_we     = r_ram_we;
   assign bus.ram_addr   = r_ram_addr;
   assign bus.ram_w_data = r_ram_wdata;
endmodule

// File: tb/tb_mac_ram_arbiter.sv
// Self-checking bench for mac_ram_arbiter: vector table, reset/contention sequences and
// random traffic scored against a transaction-level model (grant rule, shadow memory, due-cycle map).
module tb_mac_ram_arbiter;
   localparam int RD_LAT = 1;

   typedef struct packed {
      logic        req0, we0;
      logic [8:0]  addr0;
      logic [31:0] wd0;
      logic        req1, we1;
      logic [8:0]  addr1;
      logic [31:0] wd1;
      logic        eg0, eg1;
   } stim_t;

   logic clk, rst_n;
   mac_ram_arbiter_if #(.data_w(32), .ram_add_w(9)) bus ();

   mac_ram_arbiter #(.data_w(32), .ram_d(512), .ram_add_w(9), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM with RD_LAT-cycle registered read.
   logic [31:0] mem [512];
   logic [31:0] rpipe [RD_LAT];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_w_data;
      rpipe[0] <= bus.ram_we ? bus.ram_w_data : mem[bus.ram_addr];
      for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign bus.ram_r_data = rpipe[RD_LAT-1];

   int          n_chk = 0, n_fail = 0, cyc = 0;
   logic [31:0] shadow [512];
   logic [31:0] exp0 [int];
   logic [31:0] exp1 [int];
   logic [31:0] last0, last1, m_wd;
   logic [8:0]  m_addr;
   logic        m_we, fav;
   logic        p_req [2], p_we [2];
   logic [8:0]  p_addr [2];
   logic [31:0] p_wd [2];
   stim_t       tab [17];

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic stim_t mk(input logic r0, w0, input int a0, input logic [31:0] d0,
                                input logic r1, w1, input int a1, input logic [31:0] d1,
                                input logic g0, g1);
      stim_t s;
      s.req0 = r0; s.we0 = w0; s.addr0 = 9'(a0); s.wd0 = d0;
      s.req1 = r1; s.we1 = w1; s.addr1 = 9'(a1); s.wd1 = d1;
      s.eg0 = g0; s.eg1 = g1;
      return s;
   endfunction

   task automatic drive_idle();
      bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
`ifdef ARB_LOCK_EN
      bus.lock0 = 0; bus.lock1 = 0;
`endif
   endtask

   task automatic model_reset();
      exp0.delete(); exp1.delete();
      last0 = '0; last1 = '0; m_we = 0; m_addr = '0; m_wd = '0; fav = 0;
      p_req[0] = 0; p_req[1] = 0;
   endtask

   task automatic do_reset();
      #2 rst_n = 0;
      drive_idle();
      #1;
      chk1("rst_ram_we", bus.ram_we, 1'b0);
      chkw("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chkw("rst_ram_w_data", bus.ram_w_data, 32'd0);
      chk1("rst_rvalid0", bus.rvalid0, 1'b0);
      chk1("rst_rvalid1", bus.rvalid1, 1'b0);
      chkw("rst_rdata0", bus.rdata0, 32'd0);
      chkw("rst_rdata1", bus.rdata1, 32'd0);
      repeat (2) begin @(negedge clk); cyc++; end
      rst_n = 1;
      model_reset();
   endtask

   task automatic check_regs();
      logic v0, v1;
      chk1("ram_we", bus.ram_we, m_we);
      chkw("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
      chkw("ram_w_data", bus.ram_w_data, m_wd);
      v0 = exp0.exists(cyc);
      v1 = exp1.exists(cyc);
      if (v0) begin last0 = exp0[cyc]; exp0.delete(cyc); end
      if (v1) begin last1 = exp1[cyc]; exp1.delete(cyc); end
      chk1("rvalid0", bus.rvalid0, v0);
      chk1("rvalid1", bus.rvalid1, v1);
      chkw("rdata0", bus.rdata0, last0);
      chkw("rdata1", bus.rdata1, last1);
   endtask

   // One cycle: score registered outputs, apply inputs, score grants, advance the model.
   task automatic step(input stim_t s, input bit use_tab, output logic mg0, output logic mg1,
                       output logic dg0);
      logic        w;
      logic [8:0]  a;
      logic [31:0] d;
      check_regs();
      bus.req0 = s.req0; bus.we0 = s.we0; bus.addr0 = s.addr0; bus.wdata0 = s.wd0;
      bus.req1 = s.req1; bus.we1 = s.we1; bus.addr1 = s.addr1; bus.wdata1 = s.wd1;
      #1;
      mg0 = s.req0 && (!s.req1 || fav == 0);
      mg1 = s.req1 && !mg0;
      dg0 = bus.gnt0;
      chk1("gnt0", bus.gnt0, mg0);
      chk1("gnt1", bus.gnt1, mg1);
      if (use_tab) begin
         chk1("tab_gnt0", bus.gnt0, s.eg0);
         chk1("tab_gnt1", bus.gnt1, s.eg1);
      end
      if (mg0 || mg1) begin
         fav = mg0;
         w = mg0 ? s.we0 : s.we1;
         a = mg0 ? s.addr0 : s.addr1;
         d = mg0 ? s.wd0 : s.wd1;
         m_we = w; m_addr = a; m_wd = d;
         if (w) shadow[a] = d;
         else if (mg0) exp0[cyc + 2 + RD_LAT] = shadow[a];
         else exp1[cyc + 2 + RD_LAT] = shadow[a];
      end else begin
         m_we = 0;
      end
      @(negedge clk); cyc++;
   endtask

   task automatic new_txn(input int r);
      p_req[r] = 1;
      p_we[r] = 1'($urandom % 2);
      p_addr[r] = 9'($urandom_range(2, 7));
      p_wd[r] = $urandom;
   endtask

   function automatic stim_t from_pend();
      return mk(p_req[0], p_we[0], int'(p_addr[0]), p_wd[0],
                p_req[1], p_we[1], int'(p_addr[1]), p_wd[1], 0, 0);
   endfunction

   task automatic idle(input int n);
      logic g0, g1, dg;
      for (int i = 0; i < n; i++) step(mk(0,0,0,0, 0,0,0,0, 0,0), 0, g0, g1, dg);
   endtask

`ifdef ARB_LOCK_EN
   task automatic lock_run(input int hold, input bit drop_after);
      do_reset();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 9'd2; bus.lock0 = 1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 9'd3;
      for (int i = 0; i < hold; i++) begin
         #1;
         chk1("lock_gnt0", bus.gnt0, i != 16);
         chk1("lock_gnt1", bus.gnt1, i == 16);
         @(negedge clk); cyc++;
      end
      if (drop_after) begin
         bus.req0 = 0; bus.lock0 = 0;
         #1;
         chk1("lock_release_gnt1", bus.gnt1, 1'b1);
         @(negedge clk); cyc++;
      end
      do_reset();
   endtask
`endif

   initial begin
      logic g0, g1, dg;
      rst_n = 0;
      drive_idle();
      for (int i = 0; i < 512; i++) shadow[i] = '0;
      model_reset();

      tab[0]  = mk(0,0,0,0,            1,1,5,32'hDEADBEEF, 0,1);
      tab[1]  = mk(0,0,0,0,            0,0,0,0,            0,0);
      tab[2]  = mk(1,1,2,32'h11,       1,1,3,32'h22,       1,0);
      tab[3]  = mk(1,1,4,32'h44,       1,1,3,32'h22,       0,1);
      tab[4]  = mk(1,1,4,32'h44,       0,0,0,0,            1,0);
      tab[5]  = mk(1,0,5,0,            0,0,0,0,            1,0);
      tab[6]  = mk(1,1,6,32'h66,       1,0,3,0,            0,1);
      tab[7]  = mk(1,1,6,32'h66,       1,0,2,0,            1,0);
      tab[8]  = mk(0,0,0,0,            1,0,2,0,            0,1);
      tab[9]  = mk(1,0,2,0,            1,0,3,0,            1,0);
      tab[10] = mk(0,0,0,0,            1,0,3,0,            0,1);
      tab[11] = mk(1,1,7,32'h77,       0,0,0,0,            1,0);
      tab[12] = mk(0,0,0,0,            1,0,7,0,            0,1);
      for (int i = 13; i < 17; i++) tab[i] = mk(0,0,0,0, 0,0,0,0, 0,0);

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 17; i++) step(tab[i], 1, g0, g1, dg);

      // Reset while a read is in flight: its rvalid must never appear.
      step(mk(1,0,5,0, 0,0,0,0, 1,0), 1, g0, g1, dg);
      idle(1);
      do_reset();
      idle(4);

      // Sustained contention right after reset starts at requester 0 and alternates.
      new_txn(0); new_txn(1);
      for (int i = 0; i < 6; i++) begin
         step(from_pend(), 0, g0, g1, dg);
         chk1("contend_alt", dg, (i % 2) == 0);
         if (g0) new_txn(0);
         if (g1) new_txn(1);
      end
      p_req[0] = 0; p_req[1] = 0;
      idle(5);

      for (int n = 0; n < 400; n++) begin
         for (int r = 0; r < 2; r++) begin
            if (!p_req[r]) begin
               if ($urandom % 4 != 0) new_txn(r);
            end else if ($urandom % 16 == 0) begin
               p_req[r] = 0;
            end
         end
         step(from_pend(), 0, g0, g1, dg);
         if (g0) p_req[0] = 0;
         if (g1) p_req[1] = 0;
      end
      p_req[0] = 0; p_req[1] = 0;
      idle(6);
      chkw("drain0", 32'(exp0.num()), 32'd0);
      chkw("drain1", 32'(exp1.num()), 32'd0);

`ifdef ARB_LOCK_EN
      lock_run(4, 1);
      lock_run(20, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
